// File: rtl/memory_access.sv
// rtl/memory_access.sv - MEM-stage load/store unit driving a request/ready data-memory bus
module memory_access #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              memRead_MEM,
  input  logic              memWrite_MEM,
  input  logic [2:0]        funct3_MEM,
  input  logic [31:0]       ALUResult_MEM,
  input  logic [31:0]       writeData_MEM,
  output logic              dmemReq,
  output logic              dmemWe,
  output logic [ADDR_W-1:0] dmemAddr,
  output logic [3:0]        dmemBe,
  output logic [31:0]       dmemWdata,
  input  logic [31:0]       dmemRdata,
  input  logic              dmemReady,
  output logic [31:0]       loadOut_MEM,
  output logic              stall_MEM,
  output logic              accessFault_MEM
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [3:0]          r_be;
  logic [31:0]         r_wdata;
  logic [2:0]          r_funct3;
  logic [1:0]          r_lo;
  logic [31:0]         r_load_out;

  logic                w_any;
  logic                w_both;
  logic                w_illegal;
  logic                w_misalign;
  logic                w_fault;
  logic                w_issue;
  logic                w_capture;
  logic [ADDR_W-1:0]   w_addr_new;
  logic [3:0]          w_be_new;
  logic [31:0]         w_wdata_new;
  logic [2:0]          w_cap_f3;
  logic [1:0]          w_cap_lo;
  logic [7:0]          w_byte;
  logic [15:0]         w_half;
  logic [31:0]         w_load_ext;

  // Request decode; rst_n gates the issue so nothing reaches the bus while reset is held
  always_comb begin
    w_any      = memRead_MEM | memWrite_MEM;
    w_both     = memRead_MEM & memWrite_MEM;
    w_illegal  = (funct3_MEM == 3'b011) | (funct3_MEM[2:1] == 2'b11) |
                 (funct3_MEM[2] & memWrite_MEM);
    w_misalign = ((funct3_MEM[1:0] == 2'b01) & ALUResult_MEM[0]) |
                 ((funct3_MEM == 3'b010) & (ALUResult_MEM[1:0] != 2'b00));
    w_fault    = w_both | (w_any & (w_illegal | w_misalign));
    w_issue    = rst_n & w_any & ~w_fault & (r_state == S_IDLE);
    w_addr_new = {ALUResult_MEM[ADDR_W-1:2], 2'b00};
    w_be_new   = 4'b0000;
    w_wdata_new = 32'h0;
    case (funct3_MEM[1:0])
      2'b00:   w_be_new = 4'b0001 << ALUResult_MEM[1:0];
      2'b01:   w_be_new = ALUResult_MEM[1] ? 4'b1100 : 4'b0011;
      default: w_be_new = 4'b1111;
    endcase
    if (memWrite_MEM) begin
      case (funct3_MEM[1:0])
        2'b00:   w_wdata_new = {4{writeData_MEM[7:0]}};
        2'b01:   w_wdata_new = {2{writeData_MEM[15:0]}};
        default: w_wdata_new = writeData_MEM;
      endcase
    end
  end

  // Load extraction uses live inputs on a zero-wait issue, latched fields otherwise
  always_comb begin
    w_cap_f3  = (r_state == S_IDLE) ? funct3_MEM : r_funct3;
    w_cap_lo  = (r_state == S_IDLE) ? ALUResult_MEM[1:0] : r_lo;
    w_capture = dmemReady & ((w_issue & ~memWrite_MEM) | ((r_state == S_WAIT) & ~r_we));
    case (w_cap_lo)
      2'd0:    w_byte = dmemRdata[7:0];
      2'd1:    w_byte = dmemRdata[15:8];
      2'd2:    w_byte = dmemRdata[23:16];
      default: w_byte = dmemRdata[31:24];
    endcase
    w_half = w_cap_lo[1] ? dmemRdata[31:16] : dmemRdata[15:0];
    case (w_cap_f3)
      3'b000:  w_load_ext = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load_ext = {24'h0, w_byte};
      3'b001:  w_load_ext = {{16{w_half[15]}}, w_half};
      3'b101:  w_load_ext = {16'h0, w_half};
      default: w_load_ext = dmemRdata;
    endcase
  end

  always_comb begin
    w_next          = r_state;
    dmemReq         = 1'b0;
    dmemWe          = 1'b0;
    dmemAddr        = '0;
    dmemBe          = 4'b0000;
    dmemWdata       = 32'h0;
    stall_MEM       = 1'b0;
    accessFault_MEM = 1'b0;
    case (r_state)
      S_IDLE: begin
        accessFault_MEM = rst_n & w_fault;
        if (w_issue) begin
          dmemReq   = 1'b1;
          dmemWe    = memWrite_MEM;
          dmemAddr  = w_addr_new;
          dmemBe    = w_be_new;
          dmemWdata = w_wdata_new;
          stall_MEM = 1'b1;
          w_next    = dmemReady ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        dmemReq   = 1'b1;
        dmemWe    = r_we;
        dmemAddr  = r_addr;
        dmemBe    = r_be;
        dmemWdata = r_wdata;
        stall_MEM = 1'b1;
        if (dmemReady) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_be       <= 4'b0000;
      r_wdata    <= 32'h0;
      r_funct3   <= 3'b000;
      r_lo       <= 2'b00;
      r_load_out <= 32'h0;
    end else begin
      r_state <= w_next;
      if (w_issue) begin
        r_we     <= memWrite_MEM;
        r_addr   <= w_addr_new;
        r_be     <= w_be_new;
        r_wdata  <= w_wdata_new;
        r_funct3 <= funct3_MEM;
        r_lo     <= ALUResult_MEM[1:0];
      end
      if (w_capture) r_load_out <= w_load_ext;
    end
  end

  assign loadOut_MEM = r_load_out;

endmodule
